// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic ops plus an iterative shift-add
// multiplier with signed/unsigned long-product support.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ALUFlags,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultExtra
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_ORR   = 3'b011;
  localparam logic [2:0] OP_EOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mag_a;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  logic [CW-1:0]      cnt;

  logic               is_mul;
  logic               is_smull;
  logic               last;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_sum;
  logic [WIDTH:0]     step;
  logic [2*WIDTH-1:0] prod_nx;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  assign is_mul   = ALUControl[2] & |ALUControl[1:0];
  assign is_smull = ALUControl == OP_SMULL;
  // Most-negative operand still fits as an unsigned WIDTH-bit magnitude
  assign a_mag    = (is_smull & A[WIDTH-1]) ? -A : A;
  assign b_mag    = (is_smull & B[WIDTH-1]) ? -B : B;
  assign last     = cnt == CW'(WIDTH - 1);

  assign add_sum  = {1'b0, A} + {1'b0, B};
  assign sub_sum  = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);

  // Upper half accumulates, lower half shifts out multiplier bits
  assign step     = {1'b0, prod[2*WIDTH-1:WIDTH]}
                  + (prod[0] ? {1'b0, mag_a} : '0);
  assign prod_nx  = {step, prod[WIDTH-1:1]};
  assign prod_fin = neg ? -prod_nx : prod_nx;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                  (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                  (sub_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_ORR:  alu_res = A | B;
      OP_EOR:  alu_res = A ^ B;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = is_mul ? MUL : DONE;
      end
      MUL: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= '0;
      mag_a       <= '0;
      prod        <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      Result      <= '0;
      ResultExtra <= '0;
      ALUFlags    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= ALUControl;
            cnt  <= '0;
            if (is_mul) begin
              mag_a <= a_mag;
              prod  <= {{WIDTH{1'b0}}, b_mag};
              neg   <= is_smull & (A[WIDTH-1] ^ B[WIDTH-1]);
            end else begin
              Result      <= alu_res;
              ResultExtra <= '0;
              ALUFlags    <= {alu_res[WIDTH-1], ~|alu_res,
                              alu_c, alu_v};
            end
          end
        end
        MUL: begin
          prod <= prod_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            Result <= prod_fin[WIDTH-1:0];
            if (op_q == OP_MUL) begin
              ResultExtra <= '0;
              ALUFlags    <= {prod_fin[WIDTH-1],
                              ~|prod_fin[WIDTH-1:0], 2'b00};
            end else begin
              ResultExtra <= prod_fin[2*WIDTH-1:WIDTH];
              ALUFlags    <= {prod_fin[2*WIDTH-1],
                              ~|prod_fin, 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Directed-vector bench for mc_alu at WIDTH=32 and WIDTH=8.
module tb_mc_alu;

  localparam logic [2:0] ADD   = 3'd0;
  localparam logic [2:0] SUB   = 3'd1;
  localparam logic [2:0] AND   = 3'd2;
  localparam logic [2:0] ORR   = 3'd3;
  localparam logic [2:0] EOR   = 3'd4;
  localparam logic [2:0] MUL   = 3'd5;
  localparam logic [2:0] SMULL = 3'd6;
  localparam logic [2:0] UMULL = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [3:0]  flags;
  logic [31:0] res, ext;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [3:0]  flags8;
  logic [7:0]  res8, ext8;

  mc_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ALUControl(op), .A(a), .B(b),
    .busy(busy), .done(done), .ALUFlags(flags),
    .Result(res), .ResultExtra(ext)
  );

  mc_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .ALUControl(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .ALUFlags(flags8),
    .Result(res8), .ResultExtra(ext8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] ext;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[17];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run32(input string nm, input vec_t v);
    int lat;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    chk({nm, "_busy"}, busy, 1);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_lat"}, lat, v.lat);
    chk({nm, "_res"}, res, v.res);
    chk({nm, "_ext"}, ext, v.ext);
    chk({nm, "_flags"}, flags, v.fl);
    @(posedge clk); #1;
    chk({nm, "_idle"}, {busy, done}, 0);
  endtask

  task automatic run8(input string nm, input logic [2:0] o,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic [7:0] ee,
                      input logic [3:0] ef, input int el);
    int lat;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_lat"}, lat, el);
    chk({nm, "_res"}, res8, er);
    chk({nm, "_ext"}, ext8, ee);
    chk({nm, "_flags"}, flags8, ef);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'b1001, 1};
    vecs[1]  = '{SUB,   32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 4'b0110, 1};
    vecs[2]  = '{SMULL, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000, 33};
    vecs[3]  = '{UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 33};
    vecs[4]  = '{SMULL, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 4'b0000, 33};
    vecs[5]  = '{AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 4'b0000, 1};
    vecs[6]  = '{ORR,   32'h80000000, 32'h00000001, 32'h80000001, 32'h0, 4'b1000, 1};
    vecs[7]  = '{EOR,   32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 32'h0, 4'b0100, 1};
    vecs[8]  = '{ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b0110, 1};
    vecs[9]  = '{SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 4'b1000, 1};
    vecs[10] = '{SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'b0011, 1};
    vecs[11] = '{MUL,   32'h00010000, 32'h00010000, 32'h00000000, 32'h0, 4'b0100, 33};
    vecs[12] = '{MUL,   32'h00000007, 32'h00000006, 32'h0000002A, 32'h0, 4'b0000, 33};
    vecs[13] = '{SMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h0, 4'b0000, 33};
    vecs[14] = '{UMULL, 32'h00000000, 32'h12345678, 32'h00000000, 32'h0, 4'b0100, 33};
    vecs[15] = '{SMULL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000, 33};
    vecs[16] = '{MUL,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h0, 4'b1000, 33};

    reset = 1'b0; start = 1'b0; op = ADD; a = '0; b = '0;
    start8 = 1'b0; op8 = ADD; a8 = '0; b8 = '0;
    #23;
    chk("rst_ctl", {busy, done}, 0);
    chk("rst_res", {ext, res}, 0);
    chk("rst_flags", flags, 0);
    chk("rst8_all", {busy8, done8, flags8, ext8, res8}, 0);

    @(posedge clk); #1;
    reset = 1'b1;
    foreach (vecs[i]) run32($sformatf("v%0d", i), vecs[i]);

    // Start pulses during busy and in the DONE cycle must be ignored
    @(negedge clk);
    op = UMULL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        start = 1'b1; op = ADD; a = 32'd1; b = 32'd1;
      end
      if (lat == 8) start = 1'b0;
      @(posedge clk); #1; lat++;
    end
    chk("busy_start_lat", lat, 33);
    chk("busy_start_res", {ext, res}, 64'd15);
    chk("busy_start_flags", flags, 4'b0000);
    start = 1'b1; op = ADD; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_ignored", {busy, done}, 0);
    chk("hold_res1", res, 32'd15);
    @(posedge clk); #1;
    chk("hold_res2", {busy, done, res}, {2'b00, 32'd15});

    // Reset during a multiply
    @(negedge clk);
    op = UMULL; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_ctl", {busy, done}, 0);
    chk("midrst_res", {ext, res}, 0);
    chk("midrst_flags", flags, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run32("eor_after_rst",
          '{EOR, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0, 4'b0000, 1});

    run8("w8_smull", SMULL, 8'h80, 8'hFF, 8'h80, 8'h00, 4'b0000, 9);
    run8("w8_umull", UMULL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 9);
    run8("w8_add", ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1001, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
